// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RISC-V pipeline: load-use stalls,
// MEM-stage branch flushes, data-memory waits with timeout, perf counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_uses_rs1,
   input  logic             if_id_uses_rs2,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic             ex_mem_branch,
   input  logic             ex_mem_zero,
   input  logic             ex_mem_mem_read,
   input  logic             ex_mem_mem_write,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             pc_src,
   output logic [1:0]       state,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      HALT       = 2'd3
   } state_t;

   localparam logic [7:0]       TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   state_t     cur_state;
   state_t     nxt_state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;
   logic       set_fault;
   logic       flush_inc;
   logic       stall_inc;
   logic       mem_busy;
   logic       br_taken;
   logic       load_use;

   assign mem_busy = (ex_mem_mem_read | ex_mem_mem_write) & ~dmem_ready;
   assign br_taken = ex_mem_branch & ex_mem_zero;
   assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                      (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));

   assign state     = cur_state;
   assign stall_inc = (cur_state != HALT) && !pc_write;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur_state <= RUN;
         wait_cnt  <= 8'd0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_nxt;
      end
   end

   // Priority: halt/timeout > memory wait > taken branch > load-use.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
      pc_src        = 1'b0;
      nxt_state     = RUN;
      wait_nxt      = 8'd0;
      set_fault     = 1'b0;
      flush_inc     = 1'b0;
      if (!reset || cur_state == HALT) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
         nxt_state     = reset ? HALT : RUN;
      end else if (mem_busy) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
         if (wait_cnt == TIMEOUT_LAST) begin
            nxt_state = HALT;
            set_fault = 1'b1;
            wait_nxt  = wait_cnt;
         end else begin
            nxt_state = MEM_WAIT;
            wait_nxt  = wait_cnt + 8'd1;
         end
      end else if (br_taken) begin
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         flush_inc    = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         nxt_state   = LOAD_STALL;
      end
   end

   // Sticky fault and saturating performance counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_fault   <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (set_fault) begin
            mem_fault <= 1'b1;
         end
         if (stall_inc && stall_count != CNT_MAX) begin
            stall_count <= stall_count + 1'b1;
         end
         if (flush_inc && flush_count != CNT_MAX) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two instances (default and small parameters) share stimulus;
// a rule-level reference model predicts each cycle's outputs.
module tb_pipeline_hazard_ctrl;

   typedef struct {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       idex_mr;
      logic [4:0] idex_rd;
      logic       br;
      logic       zero;
      logic       mr;
      logic       mw;
      logic       ready;
   } stim_t;

   typedef struct {
      logic [8:0] ctrl;
      int         st;
      int         fault;
      int         sc;
      int         fc;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic       if_id_uses_rs1, if_id_uses_rs2, id_ex_mem_read;
   logic       ex_mem_branch, ex_mem_zero, ex_mem_mem_read, ex_mem_mem_write, dmem_ready;

   logic        pc_write_a, if_id_write_a, id_ex_write_a, ex_mem_write_a;
   logic        if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, mem_wb_bubble_a, pc_src_a;
   logic [1:0]  state_a;
   logic        mem_fault_a;
   logic [15:0] stall_count_a, flush_count_a;

   logic        pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b;
   logic        if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, mem_wb_bubble_b, pc_src_b;
   logic [1:0]  state_b;
   logic        mem_fault_b;
   logic [1:0]  stall_count_b, flush_count_b;

   int   checks = 0;
   int   failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   int m_state[2];
   int m_wcnt[2];
   int m_fault[2];
   int m_sc[2];
   int m_fc[2];
   int tmo[2];
   int cmax[2];

   pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (
      .clock(clock), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
      .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
      .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a),
      .id_ex_write(id_ex_write_a), .ex_mem_write(ex_mem_write_a),
      .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a),
      .ex_mem_flush(ex_mem_flush_a), .mem_wb_bubble(mem_wb_bubble_a),
      .pc_src(pc_src_a), .state(state_a), .mem_fault(mem_fault_a),
      .stall_count(stall_count_a), .flush_count(flush_count_a)
   );

   pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
      .clock(clock), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
      .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
      .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b),
      .id_ex_write(id_ex_write_b), .ex_mem_write(ex_mem_write_b),
      .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b),
      .ex_mem_flush(ex_mem_flush_b), .mem_wb_bubble(mem_wb_bubble_b),
      .pc_src(pc_src_b), .state(state_b), .mem_fault(mem_fault_b),
      .stall_count(stall_count_b), .flush_count(flush_count_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ctrl bit order: pc_w, ifid_w, idex_w, exmem_w, ifid_fl, idex_fl, exmem_fl, bubble, pc_src
   task automatic model_cycle(input int d, input stim_t s, output exp_t e);
      bit busy, br, lu;
      busy = (s.mr || s.mw) && !s.ready;
      br   = s.br && s.zero;
      lu   = s.idex_mr && (s.idex_rd != 0) &&
             ((s.u1 && s.rs1 == s.idex_rd) || (s.u2 && s.rs2 == s.idex_rd));
      if (!s.rst) begin
         m_state[d] = 0; m_wcnt[d] = 0; m_fault[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
         e.ctrl = 9'b000000010; e.st = 0; e.fault = 0; e.sc = 0; e.fc = 0;
         return;
      end
      e.st = m_state[d]; e.fault = m_fault[d]; e.sc = m_sc[d]; e.fc = m_fc[d];
      if (m_state[d] == 3) begin
         e.ctrl = 9'b000000010;
      end else if (busy) begin
         e.ctrl = 9'b000000010;
         if (m_sc[d] < cmax[d]) m_sc[d]++;
         if (m_wcnt[d] + 1 >= tmo[d]) begin
            m_state[d] = 3;
            m_fault[d] = 1;
         end else begin
            m_wcnt[d]++;
            m_state[d] = 2;
         end
      end else begin
         m_wcnt[d] = 0;
         if (br) begin
            e.ctrl = 9'b111111101;
            if (m_fc[d] < cmax[d]) m_fc[d]++;
            m_state[d] = 0;
         end else if (lu) begin
            e.ctrl = 9'b001101000;
            if (m_sc[d] < cmax[d]) m_sc[d]++;
            m_state[d] = 1;
         end else begin
            e.ctrl = 9'b111100000;
            m_state[d] = 0;
         end
      end
   endtask

   task automatic apply_stimulus(input stim_t s);
      exp_t e;
      @(posedge clock);
      #1;
      reset            = s.rst;
      if_id_rs1        = s.rs1;
      if_id_rs2        = s.rs2;
      if_id_uses_rs1   = s.u1;
      if_id_uses_rs2   = s.u2;
      id_ex_mem_read   = s.idex_mr;
      id_ex_rd         = s.idex_rd;
      ex_mem_branch    = s.br;
      ex_mem_zero      = s.zero;
      ex_mem_mem_read  = s.mr;
      ex_mem_mem_write = s.mw;
      dmem_ready       = s.ready;
      model_cycle(0, s, e);
      q_a.push_back(e);
      model_cycle(1, s, e);
      q_b.push_back(e);
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare at negedge.
   always @(negedge clock) begin
      exp_t e;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         check_output("a_ctrl", int'({pc_write_a, if_id_write_a, id_ex_write_a, ex_mem_write_a,
                      if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, mem_wb_bubble_a, pc_src_a}),
                      int'(e.ctrl));
         check_output("a_state", int'(state_a), e.st);
         check_output("a_fault", int'(mem_fault_a), e.fault);
         check_output("a_stall_count", int'(stall_count_a), e.sc);
         check_output("a_flush_count", int'(flush_count_a), e.fc);
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         check_output("b_ctrl", int'({pc_write_b, if_id_write_b, id_ex_write_b, ex_mem_write_b,
                      if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, mem_wb_bubble_b, pc_src_b}),
                      int'(e.ctrl));
         check_output("b_state", int'(state_b), e.st);
         check_output("b_fault", int'(mem_fault_b), e.fault);
         check_output("b_stall_count", int'(stall_count_b), e.sc);
         check_output("b_flush_count", int'(flush_count_b), e.fc);
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1'b1; s.rs1 = 5'd0; s.rs2 = 5'd0; s.u1 = 1'b0; s.u2 = 1'b0;
      s.idex_mr = 1'b0; s.idex_rd = 5'd0; s.br = 1'b0; s.zero = 1'b0;
      s.mr = 1'b0; s.mw = 1'b0; s.ready = 1'b1;
      return s;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stim_t s;
      tmo[0] = 64;    tmo[1] = 4;
      cmax[0] = 65535; cmax[1] = 3;
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0; m_wcnt[d] = 0; m_fault[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
      end
      s = idle();
      reset = 1'b0;
      if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; if_id_uses_rs1 = 1'b0; if_id_uses_rs2 = 1'b0;
      id_ex_mem_read = 1'b0; id_ex_rd = 5'd0; ex_mem_branch = 1'b0; ex_mem_zero = 1'b0;
      ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0; dmem_ready = 1'b1;

      s.rst = 1'b0;
      repeat (3) apply_stimulus(s);
      apply_stimulus(idle());

      // Load x5 in EX, ID reads x5 via rs1
      s = idle(); s.idex_mr = 1'b1; s.idex_rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1; s.rs2 = 5'd1; s.u2 = 1'b1;
      apply_stimulus(s);
      apply_stimulus(idle());

      // rd = 0 never hazards; rs2 match ignored when rs2 unused
      s = idle(); s.idex_mr = 1'b1; s.idex_rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
      apply_stimulus(s);
      s = idle(); s.idex_mr = 1'b1; s.idex_rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b0; s.rs1 = 5'd3; s.u1 = 1'b1;
      apply_stimulus(s);

      // Taken branch together with load-use: flush wins
      s = idle(); s.br = 1'b1; s.zero = 1'b1; s.idex_mr = 1'b1; s.idex_rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
      apply_stimulus(s);
      s = idle(); s.br = 1'b1; s.zero = 1'b0;
      apply_stimulus(s);

      // Three-cycle memory wait then completion
      s = idle(); s.mr = 1'b1; s.ready = 1'b0;
      repeat (3) apply_stimulus(s);
      s.ready = 1'b1;
      apply_stimulus(s);
      apply_stimulus(idle());

      // Counter saturation on the narrow instance
      s = idle(); s.rst = 1'b0;
      apply_stimulus(s);
      s = idle(); s.idex_mr = 1'b1; s.idex_rd = 5'd9; s.rs2 = 5'd9; s.u2 = 1'b1;
      repeat (5) apply_stimulus(s);
      apply_stimulus(idle());

      // Timeout on the narrow instance, reset mid-HALT
      s = idle(); s.mw = 1'b1; s.ready = 1'b0;
      repeat (6) apply_stimulus(s);
      s = idle(); s.br = 1'b1; s.zero = 1'b1;
      apply_stimulus(s);
      s = idle(); s.rst = 1'b0;
      apply_stimulus(s);
      repeat (2) apply_stimulus(idle());

      // Randomized traffic with occasional reset pulses
      for (int i = 0; i < 500; i++) begin
         s.rst     = ($urandom_range(0, 59) != 0);
         s.rs1     = 5'($urandom_range(0, 3));
         s.rs2     = 5'($urandom_range(0, 3));
         s.u1      = 1'($urandom_range(0, 1));
         s.u2      = 1'($urandom_range(0, 1));
         s.idex_mr = ($urandom_range(0, 2) == 0);
         s.idex_rd = 5'($urandom_range(0, 3));
         s.br      = ($urandom_range(0, 5) == 0);
         s.zero    = 1'($urandom_range(0, 1));
         s.mr      = ($urandom_range(0, 3) == 0);
         s.mw      = ($urandom_range(0, 3) == 0);
         s.ready   = ($urandom_range(0, 3) != 0);
         apply_stimulus(s);
      end

      @(negedge clock);
      #1;
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage 32-bit RISC-V pipeline. It watches the IF/ID, ID/EX and EX/MEM pipeline registers. It generates the hold, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and the PC-source select for taken branches resolved in MEM. It also sequences multi-cycle data-memory waits with a timeout, and keeps saturating stall and flush counters.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `MEM_TIMEOUT`, 64: maximum cycles of data-memory wait before fault; legal range 2..255.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the instruction in ID.
- `if_id_uses_rs1`, `if_id_uses_rs2`  in  1 each  the ID instruction reads that source.
- `id_ex_mem_read`  in  1  the instruction in EX is a load.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_branch`, `ex_mem_zero`  in  1 each  M_branch and ALU zero held in EX/MEM.
- `ex_mem_mem_read`, `ex_mem_mem_write`  in  1 each  memory access active in MEM.
- `dmem_ready`  in  1  data memory completes the MEM access this cycle.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`  out  1 each  register load enables (0 = hold).
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  synchronous clear of that register at the next edge.
- `mem_wb_bubble`  out  1  MEM/WB captures a bubble (reg_write = 0) at the next edge.
- `pc_src`  out  1  1 = PC loads the EX/MEM branch target.
- `state`  out  2  RUN=0, LOAD_STALL=1, MEM_WAIT=2, HALT=3.
- `mem_fault`  out  1  sticky; memory timeout occurred.
- `stall_count`, `flush_count`  out  CNT_W each  performance counters.

## Operation
- Derived terms:
  - `mem_busy` = (ex_mem_mem_read | ex_mem_mem_write) & ~dmem_ready.
  - `br_taken` = ex_mem_branch & ex_mem_zero.
  - `load_use` = id_ex_mem_read & (id_ex_rd != 0) & ((if_id_uses_rs1 & rs1 == id_ex_rd) | (if_id_uses_rs2 & rs2 == id_ex_rd)).
- Outputs are combinational from state and inputs (Mealy). The default is all writes = 1, with flushes, bubble and pc_src = 0.
- Priority in RUN, LOAD_STALL and MEM_WAIT is HALT transition > mem_busy > br_taken > load_use.
- mem_busy:
  - All four writes = 0 and mem_wb_bubble = 1.
  - Next state is MEM_WAIT and wait_cnt increments.
  - If wait_cnt == MEM_TIMEOUT-1, the next state is HALT and mem_fault sets instead.
- br_taken (and not mem_busy):
  - pc_src = 1 and pc_write = 1.
  - if_id_flush, id_ex_flush and ex_mem_flush = 1.
  - load_use is ignored. flush_count increments. Next state is RUN.
- load_use (and neither of the above):
  - pc_write = if_id_write = 0 and id_ex_flush = 1.
  - Next state is LOAD_STALL.
- Otherwise: next state is RUN.
- wait_cnt clears on any cycle without mem_busy.
- LOAD_STALL and MEM_WAIT re-evaluate the same rules every cycle. A second consecutive load_use is legal and stays in LOAD_STALL.
- HALT: all writes, flushes and pc_src = 0, and mem_wb_bubble = 1. HALT is exited only by reset.
- stall_count increments on every non-HALT cycle with pc_write = 0.
- Both counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset low, asynchronous:
  - state = RUN, wait_cnt = 0, mem_fault = 0, both counters = 0.
  - All writes, flushes and pc_src = 0, and mem_wb_bubble = 1, while reset is held.
- Reset release: outputs follow the rules from the first clock edge after deassertion. Reset mid-wait or mid-HALT discards all sequencing state.
- Load-use: hazard seen in cycle N, the bubble enters EX at edge N+1, and the load result is forwardable to the re-decoded instruction in cycle N+1. Penalty is exactly 1 cycle.
- Branch taken in MEM in cycle N: the target is in PC and three bubbles are in IF/ID, ID/EX and EX/MEM after edge N+1. Penalty is 3 cycles.
- Memory wait: the pipeline freezes for every cycle with dmem_ready = 0. In the cycle dmem_ready = 1, everything advances.
- Timeout: the fault is reached on the MEM_TIMEOUT-th consecutive busy cycle.
- Simultaneous events:
  - mem_busy with br_taken cannot occur, because a branch has no memory access. If it is forced anyway, mem_busy wins.
  - br_taken with load_use: the flush wins and no stall is counted.

## Test plan
- Load of x5 in EX with ID `add x6,x5,x1` (uses_rs1 = 1) → one cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1, state 1 for one cycle, stall_count = 1.
- Load with id_ex_rd = 0 matching rs1 = 0, or a rs2 match with uses_rs2 = 0 → no stall, state stays 0.
- br_taken in the same cycle as load_use → pc_src = 1 and three flushes, flush_count = 1, stall_count = 0.
- Load in MEM with dmem_ready low for 3 cycles → writes 0 and mem_wb_bubble 1 for 3 cycles, state 2, then advance, stall_count = 3.
- MEM_TIMEOUT = 4 with dmem_ready held low → HALT entered after the 4th busy cycle, mem_fault = 1. The block stays halted until reset is pulsed low mid-HALT, then state returns to 0 with counters at 0.
- CNT_W = 2 with 5 consecutive stall cycles → stall_count reads 1, 2, 3, 3, 3.
